// File: rtl/fabric_cfg_pkg.sv
// fabric_cfg_pkg
// Shared types and constants for the eFPGA configuration controller:
//   - controller state enum
//   - OBI register word offsets (addr[4:2]) and CTRL/STATUS bit positions
//   - CRC-32 polynomial/init values and a one-word parallel update function
// Optional feature macro used by the slice: FABRIC_CFG_CRC_EN

package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4
  } cfg_state_e;

  localparam logic [2:0] RegCtrl     = 3'd0;
  localparam logic [2:0] RegStatus   = 3'd1;
  localparam logic [2:0] RegFrameSel = 3'd2;
  localparam logic [2:0] RegData     = 3'd3;
  localparam logic [2:0] RegCrc      = 3'd4;

  localparam int CtrlStartBit = 0;
  localparam int CtrlDoneBit  = 1;
  localparam int CtrlAbortBit = 2;

  localparam int StatusBusyBit       = 0;
  localparam int StatusConfiguredBit = 1;
  localparam int StatusErrBit        = 2;

  localparam logic [31:0] CrcPoly = 32'h04C11DB7;
  localparam logic [31:0] CrcInit = 32'hFFFFFFFF;

  // Non-reflected CRC-32, whole word folded in MSB first.
  function automatic logic [31:0] crc32Next(input logic [31:0] crc,
                                            input logic [31:0] data);
    logic [31:0] c;
    c = crc ^ data;
    for (int i = 0; i < 32; i++) begin
      c = c[31] ? ((c << 1) ^ CrcPoly) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/fabric_cfg_crc32.sv
// fabric_cfg_crc32
// Running CRC-32 over 32-bit words, one word per enabled cycle.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   init_i         reload the init value (wins over en_i)
//   en_i           fold data_i into the running value
//   data_i [31:0]  word to absorb
//   crc_o  [31:0]  current CRC register value

module fabric_cfg_crc32
  import fabric_cfg_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Combinational next value for the whole word
  always_comb begin
    crc_d = crc32Next(crc_q, data_i);
  end

  // Register with reload priority over update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CrcInit;
    end else if (init_i) begin
      crc_q <= CrcInit;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/fabric_cfg_ctrl.sv
// fabric_cfg_ctrl
// OBI-slave configuration controller for the eFPGA fabric. Bitstream words
// written to DATA are assembled into one frame (NumRows words) on
// frame_data_o, then the selected FrameStrobe bit is pulsed with a one-cycle
// setup and a one-cycle hold. Owns the fabric "configured" flag.
// Optional feature: define FABRIC_CFG_CRC_EN to run CRC-32 over loaded words
// (CRC register readable at offset 4); otherwise the CRC register reads 0.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   obi_req_i/we_i/be_i      OBI request, write enable, byte enables (unused)
//   obi_addr_i [23:0]        byte address, addr[4:2] selects the register
//   obi_wdata_i [31:0]       write data
//   obi_gnt_o                grant (low for DATA writes during SETUP/STROBE/HOLD)
//   obi_rvalid_o/rdata_o     response one cycle after each grant
//   frame_data_o             assembled frame to FrameData_i
//   frame_strobe_o           one-hot frame strobe to FrameStrobe_i
//   configured_o             fabric configured flag
//   busy_o                   high outside IDLE

module fabric_cfg_ctrl
  import fabric_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 5,
  parameter int NumRows         = 6,
  parameter int StrobeCycles    = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  obi_req_i,
  input  logic                                  obi_we_i,
  input  logic [3:0]                            obi_be_i,
  input  logic [23:0]                           obi_addr_i,
  input  logic [31:0]                           obi_wdata_i,
  output logic                                  obi_gnt_o,
  output logic                                  obi_rvalid_o,
  output logic [31:0]                           obi_rdata_o,
  output logic [FrameBitsPerRow*NumRows-1:0]    frame_data_o,
  output logic [MaxFramesPerCol*NumColumns-1:0] frame_strobe_o,
  output logic                                  configured_o,
  output logic                                  busy_o
);

  localparam int StrobeW = MaxFramesPerCol * NumColumns;
  localparam int IdxW    = $clog2(StrobeW);
  localparam logic [7:0] MaxFrames8 = 8'(MaxFramesPerCol);
  localparam logic [7:0] NumCols8   = 8'(NumColumns);
  localparam logic [7:0] LastWord8  = 8'(NumRows - 1);
  localparam logic [7:0] LastStb8   = 8'(StrobeCycles - 1);

  cfg_state_e                     state_q;
  logic [7:0]                     word_cnt_q;
  logic [15:0]                    frame_cnt_q;
  logic                           err_q;
  logic                           configured_q;
  logic [15:0]                    frame_sel_q;
  logic [IdxW-1:0]                strobe_idx_q;
  logic                           sel_ok_q;
  logic [7:0]                     strobe_cnt_q;
  logic [FrameBitsPerRow*NumRows-1:0] frame_data_q;
  logic [StrobeW-1:0]             frame_strobe_q;
  logic                           rvalid_q;
  logic [31:0]                    rdata_q;
  logic [31:0]                    rdata_d;

  logic        accept;
  logic        wr_acc;
  logic        rd_acc;
  logic [2:0]  reg_off;
  logic        data_wr;
  logic        sel_wr;
  logic        start_cmd;
  logic        done_cmd;
  logic        abort_cmd;
  logic        data_stall;
  logic        sel_ok;
  logic [IdxW-1:0] sel_idx;
  logic [StrobeW-1:0] strobe_onehot;
  logic [31:0] status_word;
  logic [31:0] crc_value;
  logic        unusedInputs;

  assign unusedInputs = ^{obi_be_i, obi_addr_i[23:5], obi_addr_i[1:0]};

  assign reg_off    = obi_addr_i[4:2];
  // DATA writes cannot be absorbed while the current frame is being strobed
  assign data_stall = obi_we_i && (reg_off == RegData) &&
                      ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD));
  assign obi_gnt_o  = obi_req_i && !data_stall;
  assign accept     = obi_req_i && obi_gnt_o;
  assign wr_acc     = accept && obi_we_i;
  assign rd_acc     = accept && !obi_we_i;
  assign data_wr    = wr_acc && (reg_off == RegData);
  assign sel_wr     = wr_acc && (reg_off == RegFrameSel);
  assign start_cmd  = wr_acc && (reg_off == RegCtrl) && obi_wdata_i[CtrlStartBit];
  assign done_cmd   = wr_acc && (reg_off == RegCtrl) && obi_wdata_i[CtrlDoneBit];
  assign abort_cmd  = wr_acc && (reg_off == RegCtrl) && obi_wdata_i[CtrlAbortBit];

  // Frame selection is range-checked and flattened when SETUP is entered;
  // an out-of-range index truncates harmlessly since it is never strobed.
  assign sel_ok  = (frame_sel_q[7:0] < MaxFrames8) && (frame_sel_q[15:8] < NumCols8);
  assign sel_idx = IdxW'(frame_sel_q[15:8]) * IdxW'(MaxFramesPerCol) + IdxW'(frame_sel_q[7:0]);

  always_comb begin
    strobe_onehot = '0;
    strobe_onehot[strobe_idx_q] = 1'b1;
  end

  always_comb begin
    status_word = '0;
    status_word[StatusBusyBit]       = (state_q != IDLE);
    status_word[StatusConfiguredBit] = configured_q;
    status_word[StatusErrBit]        = err_q;
    status_word[15:8]                = word_cnt_q;
    status_word[31:16]               = frame_cnt_q;
  end

  // Read data for the response cycle; writes answer with zero
  always_comb begin
    rdata_d = '0;
    if (rd_acc) begin
      case (reg_off)
        RegStatus:   rdata_d = status_word;
        RegFrameSel: rdata_d = {16'h0000, frame_sel_q};
        RegCrc:      rdata_d = crc_value;
        default:     rdata_d = '0;
      endcase
    end
  end

`ifdef FABRIC_CFG_CRC_EN
  fabric_cfg_crc32 u_crc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .init_i (start_cmd),
    .en_i   (data_wr && (state_q == LOAD)),
    .data_i (obi_wdata_i),
    .crc_o  (crc_value)
  );
`else
  assign crc_value = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= accept;
      rdata_q  <= rdata_d;
    end
  end

  // Controller FSM. ABORT beats START beats DONE; START from any state
  // restarts straight into LOAD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      word_cnt_q     <= '0;
      frame_cnt_q    <= '0;
      err_q          <= 1'b0;
      configured_q   <= 1'b0;
      frame_sel_q    <= '0;
      strobe_idx_q   <= '0;
      sel_ok_q       <= 1'b0;
      strobe_cnt_q   <= '0;
      frame_data_q   <= '0;
      frame_strobe_q <= '0;
    end else begin
      if (sel_wr) begin
        frame_sel_q <= obi_wdata_i[15:0];
      end
      if (abort_cmd) begin
        state_q        <= IDLE;
        word_cnt_q     <= '0;
        frame_strobe_q <= '0;
      end else if (start_cmd) begin
        state_q        <= LOAD;
        word_cnt_q     <= '0;
        frame_cnt_q    <= '0;
        err_q          <= 1'b0;
        configured_q   <= 1'b0;
        frame_strobe_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (data_wr) begin
              err_q <= 1'b1;
            end
          end
          LOAD: begin
            if (done_cmd) begin
              if (word_cnt_q == 8'd0) begin
                configured_q <= 1'b1;
                state_q      <= IDLE;
              end else begin
                err_q <= 1'b1;
              end
            end else if (data_wr) begin
              for (int r = 0; r < NumRows; r++) begin
                if (word_cnt_q == 8'(r)) begin
                  frame_data_q[r*FrameBitsPerRow +: FrameBitsPerRow] <= obi_wdata_i;
                end
              end
              if (word_cnt_q == LastWord8) begin
                word_cnt_q   <= '0;
                state_q      <= SETUP;
                strobe_idx_q <= sel_idx;
                sel_ok_q     <= sel_ok;
                if (!sel_ok) begin
                  err_q <= 1'b1;
                end
              end else begin
                word_cnt_q <= word_cnt_q + 8'd1;
              end
            end
          end
          SETUP: begin
            strobe_cnt_q <= '0;
            if (sel_ok_q) begin
              frame_strobe_q <= strobe_onehot;
              state_q        <= STROBE;
            end else begin
              state_q <= HOLD;
            end
          end
          STROBE: begin
            if (strobe_cnt_q == LastStb8) begin
              frame_strobe_q <= '0;
              state_q        <= HOLD;
            end else begin
              strobe_cnt_q <= strobe_cnt_q + 8'd1;
            end
          end
          HOLD: begin
            if (sel_ok_q && (frame_cnt_q != 16'hFFFF)) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            state_q <= LOAD;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign obi_rvalid_o   = rvalid_q;
  assign obi_rdata_o    = rdata_q;
  assign frame_data_o   = frame_data_q;
  assign frame_strobe_o = frame_strobe_q;
  assign configured_o   = configured_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_fabric_cfg_ctrl.sv
// tb_fabric_cfg_ctrl
// Directed bench for fabric_cfg_ctrl: frame assembly and strobe timing,
// DATA stall during strobe, DONE errors, out-of-range selection, ABORT,
// async reset during strobe, and the CRC register (FABRIC_CFG_CRC_EN).

module tb_fabric_cfg_ctrl;

  localparam int Rows    = 6;
  localparam int StrobeW = 100;

  logic         clk;
  logic         rstN;
  logic         obiReq;
  logic         obiWe;
  logic [3:0]   obiBe;
  logic [23:0]  obiAddr;
  logic [31:0]  obiWdata;
  logic         obiGnt;
  logic         obiRvalid;
  logic [31:0]  obiRdata;
  logic [191:0] frameData;
  logic [99:0]  frameStrobe;
  logic         configured;
  logic         busy;

  int vectorCount = 0;
  int missCount   = 0;

  fabric_cfg_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .obi_req_i      (obiReq),
    .obi_we_i       (obiWe),
    .obi_be_i       (obiBe),
    .obi_addr_i     (obiAddr),
    .obi_wdata_i    (obiWdata),
    .obi_gnt_o      (obiGnt),
    .obi_rvalid_o   (obiRvalid),
    .obi_rdata_o    (obiRdata),
    .frame_data_o   (frameData),
    .frame_strobe_o (frameStrobe),
    .configured_o   (configured),
    .busy_o         (busy)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs,
                             input logic [255:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // One OBI access launched just after a rising edge; returns the read data
  // captured in the response cycle and the number of cycles gnt stayed low.
  task automatic applyStimulus(input logic we, input int offset,
                               input logic [31:0] wdata,
                               output logic [31:0] rdata, output int stalls);
    @(posedge clk);
    #1;
    obiReq   = 1'b1;
    obiWe    = we;
    obiAddr  = 24'(offset * 4);
    obiWdata = wdata;
    stalls   = 0;
    rdata    = '0;
    forever begin
      @(negedge clk);
      if (obiGnt) break;
      stalls++;
      if (stalls >= 40) begin
        checkOutput("gntTimeout", 256'(stalls), 256'd0);
        obiReq = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    obiReq = 1'b0;
    obiWe  = 1'b0;
    if (!we) begin
      checkOutput("rvalid", 256'(obiRvalid), 256'd1);
      rdata = obiRdata;
    end
  endtask

  function automatic logic [31:0] crcModel(input logic [31:0] crc,
                                           input logic [31:0] word);
    logic [63:0] sh;
    sh = {crc ^ word, 32'h0};
    for (int b = 63; b >= 32; b--) begin
      if (sh[b]) sh[b-:33] = sh[b-:33] ^ {1'b1, 32'h04C11DB7};
    end
    return sh[31:0];
  endfunction

  initial begin
    logic [31:0]  rd;
    logic [191:0] expData;
    logic [99:0]  expStb;
    logic [99:0]  seenStb;
    int           st;

    obiReq = 0; obiWe = 0; obiBe = 4'hF; obiAddr = '0; obiWdata = '0;
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstStrobe", 256'(frameStrobe), 256'd0);
    checkOutput("rstData", 256'(frameData), 256'd0);
    checkOutput("rstFlags", 256'({configured, busy, obiRvalid, obiGnt}), 256'd0);
    checkOutput("rstRdata", 256'(obiRdata), 256'd0);
    rstN = 1'b1;

    // Frame 1: col 2 frame 5 -> strobe bit 45
    applyStimulus(1, 0, 32'h1, rd, st);
    applyStimulus(1, 2, 32'h0000_0205, rd, st);
    checkOutput("wrRvalid", 256'({obiRvalid, obiRdata}), 256'({1'b1, 32'h0}));
    for (int k = 0; k < Rows; k++) applyStimulus(1, 3, 32'(k + 1) * 32'h11, rd, st);
    expData = '0;
    for (int k = 0; k < Rows; k++) expData[k*32 +: 32] = 32'(k + 1) * 32'h11;
    expStb = '0;
    expStb[2*20 + 5] = 1'b1;
    @(negedge clk);
    checkOutput("setupLow", 256'(frameStrobe), 256'd0);
    checkOutput("frameData", 256'(frameData), 256'(expData));
    @(negedge clk);
    checkOutput("strobe1", 256'(frameStrobe), 256'(expStb));
    @(negedge clk);
    checkOutput("strobe2", 256'(frameStrobe), 256'(expStb));
    @(negedge clk);
    checkOutput("holdLow", 256'(frameStrobe), 256'd0);
    applyStimulus(0, 1, 32'h0, rd, st);
    checkOutput("statusF1", 256'(rd), 256'h0001_0001);

    // Frame 2 then a DATA write during STROBE stalls until HOLD is over
    for (int k = 0; k < Rows; k++) applyStimulus(1, 3, 32'hA0 + 32'(k), rd, st);
    applyStimulus(1, 3, 32'h0000_00B1, rd, st);
    checkOutput("stallCycles", 256'(st), 256'd3);
    checkOutput("slice0", 256'(frameData[31:0]), 256'h0000_00B1);
    applyStimulus(0, 1, 32'h0, rd, st);
    checkOutput("statusStall", 256'(rd), 256'h0002_0101);

    // DONE with a partial frame, then finish the frame and DONE again
    applyStimulus(1, 0, 32'h1, rd, st);
    for (int k = 0; k < 3; k++) applyStimulus(1, 3, 32'hC0 + 32'(k), rd, st);
    applyStimulus(1, 0, 32'h2, rd, st);
    applyStimulus(0, 1, 32'h0, rd, st);
    checkOutput("statusEarlyDone", 256'(rd), 256'h0000_0305);
    for (int k = 3; k < Rows; k++) applyStimulus(1, 3, 32'hC0 + 32'(k), rd, st);
    repeat (4) @(posedge clk);
    applyStimulus(1, 0, 32'h2, rd, st);
    applyStimulus(0, 1, 32'h0, rd, st);
    checkOutput("statusDone", 256'(rd), 256'h0001_0006);
    checkOutput("configuredHi", 256'(configured), 256'd1);

    // Out-of-range column: no strobe, err set, frame_cnt unchanged
    applyStimulus(1, 0, 32'h1, rd, st);
    applyStimulus(1, 2, 32'h0000_0500, rd, st);
    for (int k = 0; k < Rows; k++) applyStimulus(1, 3, 32'hD0 + 32'(k), rd, st);
    seenStb = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      seenStb = seenStb | frameStrobe;
    end
    checkOutput("noStrobe", 256'(seenStb), 256'd0);
    applyStimulus(0, 1, 32'h0, rd, st);
    checkOutput("statusBadSel", 256'(rd), 256'h0000_0005);
    applyStimulus(0, 2, 32'h0, rd, st);
    checkOutput("frameSelRd", 256'(rd), 256'h0000_0500);

    // ABORT in the first STROBE cycle
    applyStimulus(1, 0, 32'h1, rd, st);
    applyStimulus(1, 2, 32'h0000_0003, rd, st);
    for (int k = 0; k < Rows; k++) applyStimulus(1, 3, 32'hE0 + 32'(k), rd, st);
    applyStimulus(1, 0, 32'h4, rd, st);
    checkOutput("abortStrobe", 256'(frameStrobe), 256'd0);
    checkOutput("abortBusy", 256'(busy), 256'd0);
    applyStimulus(0, 1, 32'h0, rd, st);
    checkOutput("statusAbort", 256'(rd), 256'h0);

    // DATA write in IDLE, unmapped and write-only reads
    applyStimulus(1, 3, 32'hDEAD_BEEF, rd, st);
    applyStimulus(0, 1, 32'h0, rd, st);
    checkOutput("statusIdleData", 256'(rd), 256'h4);
    applyStimulus(0, 7, 32'h0, rd, st);
    checkOutput("unmappedRd", 256'(rd), 256'h0);
    applyStimulus(0, 0, 32'h0, rd, st);
    checkOutput("ctrlRd", 256'(rd), 256'h0);

    // Asynchronous reset during STROBE drops the strobe immediately
    applyStimulus(1, 0, 32'h1, rd, st);
    applyStimulus(1, 2, 32'h0000_0100, rd, st);
    for (int k = 0; k < Rows; k++) applyStimulus(1, 3, 32'hF0 + 32'(k), rd, st);
    @(posedge clk);
    #2;
    expStb = '0;
    expStb[20] = 1'b1;
    checkOutput("preRstStrobe", 256'(frameStrobe), 256'(expStb));
    rstN = 1'b0;
    #1;
    checkOutput("asyncRstStrobe", 256'(frameStrobe), 256'd0);
    checkOutput("asyncRstBusy", 256'(busy), 256'd0);
    @(negedge clk);
    rstN = 1'b1;

`ifdef FABRIC_CFG_CRC_EN
    begin
      logic [31:0] golden;
      golden = 32'hFFFF_FFFF;
      applyStimulus(1, 0, 32'h1, rd, st);
      for (int k = 0; k < Rows; k++) begin
        applyStimulus(1, 3, 32'h0, rd, st);
        golden = crcModel(golden, 32'h0);
      end
      applyStimulus(0, 4, 32'h0, rd, st);
      checkOutput("crcFrame", 256'(rd), 256'(golden));
      applyStimulus(1, 0, 32'h1, rd, st);
      applyStimulus(0, 4, 32'h0, rd, st);
      checkOutput("crcInit", 256'(rd), 256'hFFFF_FFFF);
    end
`else
    applyStimulus(1, 0, 32'h1, rd, st);
    applyStimulus(1, 3, 32'h1234_5678, rd, st);
    applyStimulus(0, 4, 32'h0, rd, st);
    checkOutput("crcAbsent", 256'(rd), 256'h0);
    if (crcModel(32'hFFFF_FFFF, 32'h0) == 32'h0) $display("[TB] note: degenerate crc model");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  // Absolute watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
